// File: rtl/axil_led_slave.sv
// AXI4-Lite LED peripheral: LED_OUT plus SET/CLR/TGL aliases and an ID register.
// Define LED_BLINK_EN to add BLINK_MASK/BLINK_PERIOD and a hardware blinker.
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   s_aw*/s_w*/s_b*        AXI4-Lite write address, data and response channels
//   s_ar*/s_r*             AXI4-Lite read address and data channels
//   led_o                  LED drive, taken straight from registers
module axil_led_slave #(
    parameter int unsigned NUM_LEDS_p  = 8,
    parameter logic [31:0] LED_RESET_p = 32'h0000_0000,
    parameter logic [31:0] ID_VALUE_p  = 32'h4C45_4401
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           s_awaddr_i,
    input  logic                  s_awvalid_i,
    output logic                  s_awready_o,
    input  logic [31:0]           s_wdata_i,
    input  logic [3:0]            s_wstrb_i,
    input  logic                  s_wvalid_i,
    output logic                  s_wready_o,
    output logic [1:0]            s_bresp_o,
    output logic                  s_bvalid_o,
    input  logic                  s_bready_i,
    input  logic [31:0]           s_araddr_i,
    input  logic                  s_arvalid_i,
    output logic                  s_arready_o,
    output logic [31:0]           s_rdata_o,
    output logic [1:0]            s_rresp_o,
    output logic                  s_rvalid_o,
    input  logic                  s_rready_i,
    output logic [NUM_LEDS_p-1:0] led_o
);

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_RESP = 1'b1;

    localparam logic [9:0] OFF_OUT = 10'd0;
    localparam logic [9:0] OFF_SET = 10'd1;
    localparam logic [9:0] OFF_CLR = 10'd2;
    localparam logic [9:0] OFF_TGL = 10'd3;
    localparam logic [9:0] OFF_ID  = 10'd4;
`ifdef LED_BLINK_EN
    localparam logic [9:0] OFF_BMASK = 10'd5;
    localparam logic [9:0] OFF_BPER  = 10'd6;
`endif

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [0:0]            wstate_q, wstate_d;
    logic                  aw_held_q, aw_held_d;
    logic [9:0]            awoff_q, awoff_d;
    logic                  w_held_q, w_held_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [NUM_LEDS_p-1:0] led_q, led_d;
    logic [0:0]            rstate_q, rstate_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    logic        aw_hs, w_hs, commit;
    logic [9:0]  wr_off;
    logic [31:0] wr_data, bmask, masked;
    logic [31:0] led32, led_nx;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;

`ifdef LED_BLINK_EN
    logic [NUM_LEDS_p-1:0] blmask_q, blmask_d;
    logic [31:0]           bper_q, bper_d;
    logic [31:0]           cnt_q, cnt_d;
    logic                  phase_q, phase_d;
    logic                  bper_wr;
    logic [31:0]           blmask32, blmask_nx;
`endif

    assign s_awready_o = (wstate_q == W_IDLE) && !aw_held_q;
    assign s_wready_o  = (wstate_q == W_IDLE) && !w_held_q;
    assign s_bvalid_o  = (wstate_q == W_RESP);
    assign s_bresp_o   = bresp_q;
    assign s_arready_o = (rstate_q == R_IDLE);
    assign s_rvalid_o  = (rstate_q == R_RESP);
    assign s_rdata_o   = rdata_q;
    assign s_rresp_o   = rresp_q;

    assign aw_hs  = s_awvalid_i && s_awready_o;
    assign w_hs   = s_wvalid_i && s_wready_o;
    assign commit = (wstate_q == W_IDLE)
                    && (aw_held_q || aw_hs)
                    && (w_held_q || w_hs);

    // A channel handshaking on the commit edge has not been latched yet,
    // so take it straight from the bus.
    assign wr_off  = aw_hs ? s_awaddr_i[11:2] : awoff_q;
    assign wr_data = w_hs ? s_wdata_i : wdata_q;

    always_comb begin
        bmask = '0;
        for (int i = 0; i < 4; i++) begin
            bmask[8*i +: 8] = {8{w_hs ? s_wstrb_i[i] : wstrb_q[i]}};
        end
    end

    assign masked = wr_data & bmask;

    // Zero-extended views so bits above NUM_LEDS_p read as 0.
    always_comb begin
        led32 = '0;
        led32[NUM_LEDS_p-1:0] = led_q;
    end

`ifdef LED_BLINK_EN
    always_comb begin
        blmask32 = '0;
        blmask32[NUM_LEDS_p-1:0] = blmask_q;
    end
`endif

    always_comb begin
        wstate_d  = wstate_q;
        aw_held_d = aw_held_q;
        awoff_d   = awoff_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        led_nx    = led32;
`ifdef LED_BLINK_EN
        blmask_nx = blmask32;
        bper_d    = bper_q;
        bper_wr   = 1'b0;
`endif
        unique case (wstate_q)
            W_IDLE: begin
                if (commit) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    wstate_d  = W_RESP;
                    bresp_d   = RESP_OKAY;
                    case (wr_off)
                        OFF_OUT: led_nx = (led32 & ~bmask) | masked;
                        OFF_SET: led_nx = led32 | masked;
                        OFF_CLR: led_nx = led32 & ~masked;
                        OFF_TGL: led_nx = led32 ^ masked;
                        OFF_ID:  ;
`ifdef LED_BLINK_EN
                        OFF_BMASK: blmask_nx = (blmask32 & ~bmask) | masked;
                        OFF_BPER: begin
                            bper_d  = (bper_q & ~bmask) | masked;
                            bper_wr = 1'b1;
                        end
`endif
                        default: bresp_d = RESP_SLVERR;
                    endcase
                end else begin
                    if (aw_hs) begin
                        aw_held_d = 1'b1;
                        awoff_d   = s_awaddr_i[11:2];
                    end
                    if (w_hs) begin
                        w_held_d = 1'b1;
                        wdata_d  = s_wdata_i;
                        wstrb_d  = s_wstrb_i;
                    end
                end
            end
            W_RESP: begin
                if (s_bready_i) wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
        led_d = led_nx[NUM_LEDS_p-1:0];
`ifdef LED_BLINK_EN
        blmask_d = blmask_nx[NUM_LEDS_p-1:0];
`endif
    end

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        case (s_araddr_i[11:2])
            OFF_OUT: rd_data = led32;
            OFF_SET, OFF_CLR, OFF_TGL: ;
            OFF_ID:  rd_data = ID_VALUE_p;
`ifdef LED_BLINK_EN
            OFF_BMASK: rd_data = blmask32;
            OFF_BPER:  rd_data = bper_q;
`endif
            default: rd_resp = RESP_SLVERR;
        endcase
    end

    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        unique case (rstate_q)
            R_IDLE: begin
                if (s_arvalid_i) begin
                    rdata_d  = rd_data;
                    rresp_d  = rd_resp;
                    rstate_d = R_RESP;
                end
            end
            R_RESP: begin
                if (s_rready_i) rstate_d = R_IDLE;
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wstate_q  <= W_IDLE;
            aw_held_q <= 1'b0;
            awoff_q   <= '0;
            w_held_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RESP_OKAY;
            led_q     <= LED_RESET_p[NUM_LEDS_p-1:0];
            rstate_q  <= R_IDLE;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            wstate_q  <= wstate_d;
            aw_held_q <= aw_held_d;
            awoff_q   <= awoff_d;
            w_held_q  <= w_held_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
            led_q     <= led_d;
            rstate_q  <= rstate_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

`ifdef LED_BLINK_EN
    // A period write restarts the blink cycle from phase 0.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (bper_wr || bper_q == 32'd0) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == bper_q - 32'd1) begin
            cnt_d   = '0;
            phase_d = !phase_q;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            blmask_q <= '0;
            bper_q   <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
        end else begin
            blmask_q <= blmask_d;
            bper_q   <= bper_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
        end
    end

    assign led_o = led_q ^ (blmask_q & {NUM_LEDS_p{phase_q}});

    logic unused_bits;
    assign unused_bits = ^{s_awaddr_i[31:12], s_awaddr_i[1:0],
                           s_araddr_i[31:12], s_araddr_i[1:0],
                           led_nx, blmask_nx};
`else
    assign led_o = led_q;

    logic unused_bits;
    assign unused_bits = ^{s_awaddr_i[31:12], s_awaddr_i[1:0],
                           s_araddr_i[31:12], s_araddr_i[1:0],
                           led_nx};
`endif

endmodule

// File: tb/tb_axil_led_slave.sv
// Scoreboard bench for axil_led_slave: stimulus pushes expected B/R
// responses, negedge monitors pop and compare on each handshake.
module tb_axil_led_slave;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] s_awaddr_i;
    logic        s_awvalid_i;
    logic        s_awready_o;
    logic [31:0] s_wdata_i;
    logic [3:0]  s_wstrb_i;
    logic        s_wvalid_i;
    logic        s_wready_o;
    logic [1:0]  s_bresp_o;
    logic        s_bvalid_o;
    logic        s_bready_i;
    logic [31:0] s_araddr_i;
    logic        s_arvalid_i;
    logic        s_arready_o;
    logic [31:0] s_rdata_o;
    logic [1:0]  s_rresp_o;
    logic        s_rvalid_o;
    logic        s_rready_i;
    logic [7:0]  led_o;

    always #5 clk = ~clk;

    axil_led_slave dut (
        .clk_i(clk), .rst_i(rst_i),
        .s_awaddr_i(s_awaddr_i), .s_awvalid_i(s_awvalid_i),
        .s_awready_o(s_awready_o),
        .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i),
        .s_wvalid_i(s_wvalid_i), .s_wready_o(s_wready_o),
        .s_bresp_o(s_bresp_o), .s_bvalid_o(s_bvalid_o),
        .s_bready_i(s_bready_i),
        .s_araddr_i(s_araddr_i), .s_arvalid_i(s_arvalid_i),
        .s_arready_o(s_arready_o),
        .s_rdata_o(s_rdata_o), .s_rresp_o(s_rresp_o),
        .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i),
        .led_o(led_o)
    );

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    rexp_t      rq[$];
    logic [1:0] bq[$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timeout waiting for handshake", name);
    endtask

    // Monitors: a handshake completes on the posedge after a negedge
    // that sees valid && ready.
    always @(negedge clk) begin
        logic [1:0] eb;
        if (!rst_i && s_bvalid_o && s_bready_i) begin
            if (bq.size() == 0) begin
                timeout("b_unexpected");
            end else begin
                eb = bq.pop_front();
                chk("bresp", 32'(s_bresp_o), 32'(eb));
            end
        end
    end

    always @(negedge clk) begin
        rexp_t er;
        if (!rst_i && s_rvalid_o && s_rready_i) begin
            if (rq.size() == 0) begin
                timeout("r_unexpected");
            end else begin
                er = rq.pop_front();
                chk("rdata", s_rdata_o, er.data);
                chk("rresp", 32'(s_rresp_o), 32'(er.resp));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    task automatic do_aw(input logic [31:0] a);
        int n = 0;
        s_awaddr_i  = a;
        s_awvalid_i = 1'b1;
        @(negedge clk);
        while (!s_awready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeout("aw");
        @(posedge clk);
        #1 s_awvalid_i = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        s_wdata_i  = d;
        s_wstrb_i  = s;
        s_wvalid_i = 1'b1;
        @(negedge clk);
        while (!s_wready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeout("w");
        @(posedge clk);
        #1 s_wvalid_i = 1'b0;
    endtask

    task automatic wait_b();
        int n = 0;
        @(negedge clk);
        while (!(s_bvalid_o && s_bready_i) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeout("b");
        @(posedge clk);
        #1;
    endtask

    // lead > 0: AW leads W by that many cycles; lead < 0: W leads.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int lead,
                            input logic [1:0] er);
        bq.push_back(er);
        fork
            begin
                if (lead < 0) begin
                    repeat (-lead) @(posedge clk);
                    #1;
                end
                do_aw(a);
            end
            begin
                if (lead > 0) begin
                    repeat (lead) @(posedge clk);
                    #1;
                end
                do_w(d, s);
            end
        join
        chk("bvalid_latency", 32'(s_bvalid_o), 32'd1);
        wait_b();
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] ed,
                           input logic [1:0] er);
        int n = 0;
        rexp_t e;
        e.data = ed;
        e.resp = er;
        rq.push_back(e);
        s_araddr_i  = a;
        s_arvalid_i = 1'b1;
        @(negedge clk);
        while (!s_arready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeout("ar");
        @(posedge clk);
        #1 s_arvalid_i = 1'b0;
        chk("rvalid_latency", 32'(s_rvalid_o), 32'd1);
        n = 0;
        @(negedge clk);
        while (!(s_rvalid_o && s_rready_i) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeout("r");
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic hold_ok;
        logic [1:0] blink_resp;
        int n;
`ifdef LED_BLINK_EN
        blink_resp = OKAY;
`else
        blink_resp = SLVERR;
`endif
        rst_i       = 1'b1;
        s_awaddr_i  = '0;
        s_awvalid_i = 1'b0;
        s_wdata_i   = '0;
        s_wstrb_i   = '0;
        s_wvalid_i  = 1'b0;
        s_bready_i  = 1'b1;
        s_araddr_i  = '0;
        s_arvalid_i = 1'b0;
        s_rready_i  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", 32'(s_awready_o), 32'd1);
        chk("rst_wready", 32'(s_wready_o), 32'd1);
        chk("rst_arready", 32'(s_arready_o), 32'd1);
        chk("rst_bvalid", 32'(s_bvalid_o), 32'd0);
        chk("rst_rvalid", 32'(s_rvalid_o), 32'd0);
        chk("rst_rdata", s_rdata_o, 32'd0);
        chk("rst_led", 32'(led_o), 32'h00);
        rst_i = 1'b0;
        @(posedge clk);
        #1;

        do_read(32'h10, 32'h4C45_4401, OKAY);
        chk("led_after_id", 32'(led_o), 32'h00);

        do_write(32'h00, 32'h0000_00A5, 4'hF, 2, OKAY);
        chk("led_a5", 32'(led_o), 32'hA5);
        do_read(32'h00, 32'hA5, OKAY);

        do_write(32'h04, 32'h0F, 4'hF, 0, OKAY);
        chk("led_set", 32'(led_o), 32'hAF);
        do_write(32'h08, 32'h81, 4'hF, 1, OKAY);
        chk("led_clr", 32'(led_o), 32'h2E);
        do_write(32'h0C, 32'hFF, 4'hF, -1, OKAY);
        chk("led_tgl", 32'(led_o), 32'hD1);
        do_write(32'h00, 32'h00, 4'h0, 0, OKAY);
        chk("led_nostrb", 32'(led_o), 32'hD1);

        do_write(32'h0002_1000, 32'h3C, 4'h1, -2, OKAY);
        chk("led_alias", 32'(led_o), 32'h3C);
        do_write(32'h10, 32'hFFFF_FFFF, 4'hF, 0, OKAY);
        chk("led_id_wr", 32'(led_o), 32'h3C);
        do_write(32'h20, 32'hFF, 4'hF, 0, SLVERR);
        chk("led_bad_wr", 32'(led_o), 32'h3C);
        do_write(32'h00, 32'hFFFF_FF00, 4'hE, 0, OKAY);
        chk("led_partial", 32'(led_o), 32'h3C);
        do_write(32'h04, 32'h0000_FFFF, 4'h2, 0, OKAY);
        chk("led_set_b1", 32'(led_o), 32'h3C);
        do_read(32'h00, 32'h3C, OKAY);
        do_read(32'h08, 32'h0, OKAY);
        do_read(32'h14, 32'h0, blink_resp);

        s_bready_i = 1'b0;
        bq.push_back(OKAY);
        fork
            do_aw(32'h00);
            do_w(32'h55, 4'hF);
        join
        chk("led_55", 32'(led_o), 32'h55);
        hold_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (!s_bvalid_o || s_awready_o || s_wready_o) hold_ok = 1'b0;
        end
        chk("b_hold", 32'(hold_ok), 32'd1);
        s_awaddr_i  = 32'h04;
        s_awvalid_i = 1'b1;
        s_bready_i  = 1'b1;
        @(negedge clk);
        chk("aw_blocked", 32'(s_awready_o), 32'd0);
        @(posedge clk);
        #1;
        chk("b_done", 32'(s_bvalid_o), 32'd0);
        chk("aw_reopen", 32'(s_awready_o), 32'd1);
        @(posedge clk);
        #1 s_awvalid_i = 1'b0;
        chk("aw_taken", 32'(s_awready_o), 32'd0);
        bq.push_back(OKAY);
        do_w(32'h0F, 4'hF);
        chk("bvalid_after_w", 32'(s_bvalid_o), 32'd1);
        wait_b();
        chk("led_5f", 32'(led_o), 32'h5F);
        do_read(32'h20, 32'h0, SLVERR);

        do_write(32'h00, 32'h11, 4'hF, 0, OKAY);
        rq.push_back('{data: 32'h11, resp: OKAY});
        bq.push_back(OKAY);
        s_araddr_i  = 32'h00;
        s_arvalid_i = 1'b1;
        s_awaddr_i  = 32'h00;
        s_awvalid_i = 1'b1;
        s_wdata_i   = 32'h22;
        s_wstrb_i   = 4'hF;
        s_wvalid_i  = 1'b1;
        @(posedge clk);
        #1;
        s_arvalid_i = 1'b0;
        s_awvalid_i = 1'b0;
        s_wvalid_i  = 1'b0;
        chk("led_22", 32'(led_o), 32'h22);
        chk("sim_rvalid", 32'(s_rvalid_o), 32'd1);
        chk("sim_bvalid", 32'(s_bvalid_o), 32'd1);
        @(posedge clk);
        #1;

        s_rready_i  = 1'b0;
        s_araddr_i  = 32'h00;
        s_arvalid_i = 1'b1;
        @(posedge clk);
        #1 s_arvalid_i = 1'b0;
        @(posedge clk);
        #1;
        chk("pend_rvalid", 32'(s_rvalid_o), 32'd1);
        chk("pend_rdata", s_rdata_o, 32'h22);
        rst_i = 1'b1;
        #1;
        chk("mid_rst_rvalid", 32'(s_rvalid_o), 32'd0);
        chk("mid_rst_rdata", s_rdata_o, 32'd0);
        chk("mid_rst_led", 32'(led_o), 32'h00);
        chk("mid_rst_arready", 32'(s_arready_o), 32'd1);
        @(posedge clk);
        #1;
        rst_i      = 1'b0;
        s_rready_i = 1'b1;
        @(posedge clk);
        #1;
        do_read(32'h00, 32'h0, OKAY);

`ifdef LED_BLINK_EN
        do_write(32'h14, 32'h01, 4'hF, 0, OKAY);
        do_write(32'h18, 32'h04, 4'hF, 0, OKAY);
        chk("blink_p0", 32'(led_o[0]), 32'd0);
        repeat (3) @(posedge clk);
        #1 chk("blink_p1", 32'(led_o[0]), 32'd1);
        repeat (3) @(posedge clk);
        #1 chk("blink_p1_hold", 32'(led_o[0]), 32'd1);
        @(posedge clk);
        #1 chk("blink_p0_again", 32'(led_o[0]), 32'd0);
        do_write(32'h18, 32'h00, 4'hF, 0, OKAY);
        chk("blink_off", 32'(led_o[0]), 32'd0);
        repeat (10) @(posedge clk);
        #1 chk("blink_off_hold", 32'(led_o[0]), 32'd0);
`endif

        n = 0;
        while ((rq.size() != 0 || bq.size() != 0) && n < 20) begin
            @(posedge clk);
            n++;
        end
        chk("scoreboard_drained", 32'(rq.size() + bq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axil_led_slave.md
Name: axil_led_slave

Overview:
AXI4-Lite responder for the LED peripheral on crossbar slave port 2 (0x0002_0000–0x0002_FFFF), downstream of the AXI4-to-Lite converter. It is the responder end of the picorv32 initiator's accesses. It holds a small register file that drives the board LEDs, with write-1-to-set, write-1-to-clear and toggle aliases. It returns OKAY/SLVERR responses with full valid/ready handshaking on all five channels.

Parameters:
NUM_LEDS_p, 8, number of LED outputs (legal range 1..32).
LED_RESET_p, 32'h0000_0000, reset value of the LED register; only bits [NUM_LEDS_p-1:0] are used.
ID_VALUE_p, 32'h4C45_4401, constant returned by the ID register.

Ports:
clk_i  in  1  clock; all logic is on the rising edge.
rst_i  in  1  asynchronous reset, active-high.
s_awaddr_i  in  32  write address.
s_awvalid_i  in  1  write address valid.
s_awready_o  out  1  write address ready.
s_wdata_i  in  32  write data.
s_wstrb_i  in  4  write byte strobes.
s_wvalid_i  in  1  write data valid.
s_wready_o  out  1  write data ready.
s_bresp_o  out  2  write response.
s_bvalid_o  out  1  write response valid.
s_bready_i  in  1  write response ready.
s_araddr_i  in  32  read address.
s_arvalid_i  in  1  read address valid.
s_arready_o  out  1  read address ready.
s_rdata_o  out  32  read data.
s_rresp_o  out  2  read response.
s_rvalid_o  out  1  read response valid.
s_rready_i  in  1  read response ready.
led_o  out  NUM_LEDS_p  LED drive; a registered output.

Behaviour:
- Reset values:
  - led_o = LED_RESET_p[NUM_LEDS_p-1:0].
  - bvalid = 0, rvalid = 0, rdata = 0, bresp = 0, rresp = 0.
  - awready, wready and arready are 1 (write and read FSMs in IDLE; AW/W holding flags clear).
- Decode:
  - Word offset is addr[11:2]; addr[1:0] and addr[31:12] are ignored.
  - 0x00 LED_OUT: RW, byte-strobed.
  - 0x04 LED_SET: WO, OR-in wdata.
  - 0x08 LED_CLR: WO, AND-NOT wdata.
  - 0x0C LED_TGL: WO, XOR wdata.
  - 0x10 ID: RO.
- Read-back values:
  - Reads of 0x04, 0x08 and 0x0C return 0 with OKAY.
  - A write to ID is ignored and returns OKAY.
  - Any other offset returns SLVERR (2'b10); read data is 0 and a write has no effect.
- Strobes:
  - LED_OUT updates only the bytes whose wstrb bit is set.
  - SET/CLR/TGL are masked per byte by wstrb.
  - Bits at or above NUM_LEDS_p are not stored and read as 0.
- Write FSM (W_IDLE, W_RESP):
  - In W_IDLE, AW and W are accepted independently in any order or in the same cycle.
  - awready = !aw_held; wready = !w_held.
  - When both are held, or both handshake in the same cycle: commit the register update on that edge, set bvalid and bresp, clear the held flags, go to W_RESP.
  - In W_RESP: awready = wready = 0; bvalid and bresp stay stable until bready; then go to W_IDLE.
  - Minimum latency is 1 cycle from the joint AW/W handshake to bvalid.
- Read FSM (R_IDLE, R_RESP):
  - In R_IDLE, arready = 1.
  - On the AR handshake, register rdata and rresp from current register state (the value before any write committing on the same edge), assert rvalid and go to R_RESP.
  - In R_RESP: arready = 0; rdata, rresp and rvalid stay stable until rready; then go to R_IDLE.
  - Latency is 1 cycle; throughput is one read per 2 cycles.
- Concurrency:
  - The read and write FSMs are fully independent.
  - When a read and a write to LED_OUT handshake on the same edge, the read returns the old value and led_o shows the new value on the next cycle.
- Reset asserted mid-transaction:
  - All outputs immediately return to their reset values.
  - Held AW/W and pending B/R are discarded.
  - led_o returns to LED_RESET_p.
- led_o always equals the internal register; there is no extra delay.

Optional Feature:
Macro LED_BLINK_EN.
- When defined, two registers are added:
  - 0x14 BLINK_MASK: RW, NUM_LEDS_p bits, reset 0.
  - 0x18 BLINK_PERIOD: RW, 32 bits, reset 0.
- A 32-bit counter increments each cycle while BLINK_PERIOD != 0.
- When the counter reaches BLINK_PERIOD-1 it wraps to 0 and an internal phase bit toggles.
- led_o = LED_OUT ^ (BLINK_MASK & {NUM_LEDS_p{phase}}).
- Writing BLINK_PERIOD clears the counter and the phase.
- When BLINK_PERIOD == 0, the counter holds at 0 and phase is 0.
- When the macro is undefined, offsets 0x14 and 0x18 decode as SLVERR, no counter logic exists, and led_o = LED_OUT.

Test Plan:
1. Reset, then read 0x10 -> rdata 32'h4C45_4401, rresp 0, rvalid 1 cycle after the AR handshake; led_o = 8'h00.
2. Write 0x00, data 32'h0000_00A5, wstrb 4'hF, with AW two cycles before W -> led_o = 8'hA5 on the cycle after the W handshake; bresp 0; read 0x00 returns 32'hA5.
3. From led_o = 8'hA5:
   - SET 8'h0F -> led_o = 8'hAF.
   - CLR 8'h81 -> led_o = 8'h2E.
   - TGL 8'hFF -> led_o = 8'hD1.
   - Writing 0x00 with wstrb 4'h0 leaves led_o unchanged.
4. Hold bready = 0 for 5 cycles after a write -> bvalid stays 1, awready = wready = 0, and a new AW is not accepted until the cycle after the B handshake. Read 0x20 -> rresp 2'b10, rdata 0.
5. Simultaneous AR and AW+W to 0x00 (old 8'h11, new 8'h22) -> rdata 32'h11, then led_o = 8'h22. Asserting rst_i while rvalid is pending -> rvalid drops immediately and led_o = LED_RESET_p.
6. (LED_BLINK_EN) BLINK_MASK = 8'h01, BLINK_PERIOD = 4, LED_OUT = 0 -> led_o[0] toggles every 4 cycles. Writing BLINK_PERIOD = 0 -> led_o[0] = 0 and stays 0.
